// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and counter-width helpers.
package pulse_stretcher_pkg;

    typedef logic [1:0] ps_state_t;

    localparam ps_state_t ST_IDLE = 2'd0;
    localparam ps_state_t ST_HIGH = 2'd1;
    localparam ps_state_t ST_LOW  = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// Loadable down-counter that stops at zero and flags it; sets the HIGH/LOW phase lengths.
module pulse_stretcher_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width pulses with a guaranteed low gap.
// Build option PULSE_STRETCHER_COALESCE_EN merges queued events into one pending pulse.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 8,
    parameter int LOW_CYCLES  = 8,
    parameter int PEND_WIDTH  = 2
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iPulse,
    output logic oSignal,
    output logic oBusy,
    output logic oOverflow
);

    localparam int TW = cnt_width(max_int(HIGH_CYCLES, LOW_CYCLES));
    localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);

    ps_state_t        r_state;
    ps_state_t        w_state_nxt;
    logic             r_signal;
    logic             r_busy;
    logic             r_overflow;
    logic             w_tmr_zero;
    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;
    logic             w_pend_nz;
    logic             w_launch;
    logic             w_busy_evt;
    logic             w_drop;

    pulse_stretcher_timer #(
        .WIDTH (TW)
    ) u_timer (
        .i_clk      (iClk),
        .i_rst      (iReset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // The end of LOW relaunches directly into HIGH so back-to-back events see no idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = HIGH_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (iPulse) begin
                    w_state_nxt = ST_HIGH;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_LOW;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = LOW_LOAD;
                end
            end
            ST_LOW: begin
                if (w_tmr_zero) begin
                    if (w_pend_nz || iPulse) begin
                        w_state_nxt = ST_HIGH;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = HIGH_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_launch   = (r_state == ST_LOW) && w_tmr_zero && (w_pend_nz || iPulse);
    assign w_busy_evt = iPulse && (r_state != ST_IDLE);

`ifdef PULSE_STRETCHER_COALESCE_EN
    logic r_pend;

    // Any strobes during a pulse collapse into a single follow-up pulse.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_pend <= 1'b0;
        end else if (w_launch) begin
            r_pend <= 1'b0;
        end else if (w_busy_evt) begin
            r_pend <= 1'b1;
        end
    end

    assign w_pend_nz = r_pend;
    assign w_drop    = 1'b0;
`else
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    logic [PEND_WIDTH-1:0] r_pend;

    // A strobe coinciding with a launch either replaces the dequeued event or is itself launched.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_pend <= '0;
        end else if (w_launch) begin
            if (w_pend_nz && !iPulse) begin
                r_pend <= r_pend - PEND_WIDTH'(1);
            end
        end else if (w_busy_evt && (r_pend != PEND_MAX)) begin
            r_pend <= r_pend + PEND_WIDTH'(1);
        end
    end

    assign w_pend_nz = (r_pend != '0);
    assign w_drop    = w_busy_evt && !w_launch && (r_pend == PEND_MAX);
`endif

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state    <= ST_IDLE;
            r_signal   <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_signal <= (w_state_nxt == ST_HIGH);
            r_busy   <= (w_state_nxt != ST_IDLE);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign oSignal   = r_signal;
    assign oBusy     = r_busy;
    assign oOverflow = r_overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher (HIGH=4, LOW=3, PEND=2); expected traces come from the event timing plan.
module tb_pulse_stretcher;

    localparam int HC   = 4;
    localparam int LC   = 3;
    localparam int PW   = 2;
    localparam int NCYC = 45;

    logic iClk   = 1'b0;
    logic iReset = 1'b1;
    logic iPulse = 1'b0;
    logic oSignal;
    logic oBusy;
    logic oOverflow;

    always #5 iClk = ~iClk;

    pulse_stretcher #(
        .HIGH_CYCLES (HC),
        .LOW_CYCLES  (LC),
        .PEND_WIDTH  (PW)
    ) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iPulse    (iPulse),
        .oSignal   (oSignal),
        .oBusy     (oBusy),
        .oOverflow (oOverflow)
    );

    typedef struct {
        int   cyc;
        logic sig;
        logic busy;
        logic ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic stim_pulse [0:63];
    logic stim_rst   [0:63];
    logic e_sig      [0:63];
    logic e_busy     [0:63];
    logic e_ovf      [0:63];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_test();
        for (int i = 0; i < 64; i++) begin
            stim_pulse[i] = 1'b0;
            stim_rst[i]   = 1'b0;
            e_sig[i]      = 1'b0;
            e_busy[i]     = 1'b0;
            e_ovf[i]      = 1'b0;
        end
    endtask

    task automatic set_pulses(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) stim_pulse[i] = 1'b1;
    endtask

    task automatic set_win(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) e_sig[i] = 1'b1;
    endtask

    task automatic set_busy(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) e_busy[i] = 1'b1;
    endtask

    task automatic set_ovf(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) e_ovf[i] = 1'b1;
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.cyc  = k;
        e.sig  = e_sig[k];
        e.busy = e_busy[k];
        e.ovf  = e_ovf[k];
        sb.push_back(e);
    endtask

    // Cycle k is the clock period ending at posedge k; outputs are sampled mid-period on the negedge.
    task automatic run_test(input string name);
        exp_t e;
        iReset = 1'b1;
        iPulse = 1'b0;
        repeat (3) @(negedge iClk);
        sb.delete();
        push_exp(1);
        for (int k = 1; k <= NCYC; k++) begin
            if (sb.size() == 0) begin
                check_val($sformatf("%s.c%0d.sb_empty", name, k), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_val($sformatf("%s.c%0d.sig", name, e.cyc), 32'(oSignal), 32'(e.sig));
                check_val($sformatf("%s.c%0d.busy", name, e.cyc), 32'(oBusy), 32'(e.busy));
                check_val($sformatf("%s.c%0d.ovf", name, e.cyc), 32'(oOverflow), 32'(e.ovf));
            end
            iReset = stim_rst[k];
            iPulse = stim_pulse[k];
            push_exp(k + 1);
            @(negedge iClk);
        end
        iPulse = 1'b0;
    endtask

    initial begin
        clear_test();
        set_pulses(10, 10);
        set_win(11, 14);
        set_busy(11, 17);
        run_test("single");

        clear_test();
        set_pulses(10, 12);
        set_win(11, 14);
        set_win(18, 21);
        set_win(25, 28);
        set_busy(11, 31);
        run_test("burst3");

        clear_test();
        set_pulses(10, 10);
        set_pulses(17, 17);
        set_win(11, 14);
        set_win(18, 21);
        set_busy(11, 24);
        run_test("b2b");

        clear_test();
        set_pulses(10, 14);
        set_win(11, 14);
        set_win(18, 21);
`ifdef PULSE_STRETCHER_COALESCE_EN
        set_busy(11, 24);
        run_test("coalesce");
`else
        set_win(25, 28);
        set_win(32, 35);
        set_busy(11, 38);
        set_ovf(15, NCYC + 1);
        run_test("sat");
`endif

        clear_test();
        set_pulses(10, 11);
        stim_rst[12] = 1'b1;
        set_win(11, 12);
        set_busy(11, 12);
        run_test("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
